sd_clock_ctrl: RTL and testbench

Sequencer that owns the SD card clock divider's DIVIDER and reset inputs. It runs the power-up slow-clock phase and makes every later rate change glitch-safe. Each change drains the command/data masters, holds the divider in reset while the new DIVIDER value lands, then waits a settle period before releasing the bus. It sits between the SD register file (requester) and the clock divider, and stalls the CMD/DAT masters.

---
 rtl/sd_clock_ctrl_if.sv | 36 +++
 rtl/sd_clock_ctrl.sv | 154 +++++++++++++++
 tb/tb_sd_clock_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_clock_ctrl_if.sv
// Bundle between the SD clock sequencer, the register-file requester and
// the CMD/DAT masters. Signal prefixes are seen from the sequencer: i_ is
// driven into it, o_ is driven by it.
//
// Handshake: a rate-change request transfers on a rising clk edge where
// i_req_valid and o_req_ready are both high. i_req_div is sampled only on
// that edge. o_req_ready depends only on registered state, never on
// i_req_valid. The requester may change or withdraw a request freely while
// o_req_ready is low. Completion is reported by a one-cycle o_switch_done.
interface sd_clock_ctrl_if;
  logic       i_req_valid;
  logic [7:0] i_req_div;
  logic       o_req_ready;
  logic       i_cmd_busy;
  logic       i_dat_busy;
  logic       o_bus_stall;
  logic [7:0] o_divider;
  logic       o_div_rst;
  logic       o_init_done;
  logic       o_switch_done;
  logic [2:0] o_dbg_state;

  // Sequencer side.
  modport slave (
    input  i_req_valid, i_req_div, i_cmd_busy, i_dat_busy,
    output o_req_ready, o_bus_stall, o_divider, o_div_rst,
           o_init_done, o_switch_done, o_dbg_state
  );

  // Requester / master side.
  modport master (
    output i_req_valid, i_req_div, i_cmd_busy, i_dat_busy,
    input  o_req_ready, o_bus_stall, o_divider, o_div_rst,
           o_init_done, o_switch_done, o_dbg_state
  );
endinterface

// File: rtl/sd_clock_ctrl.sv
// SD clock divider sequencer. It runs the power-up slow-clock phase and then
// performs glitch-safe divider changes: drain masters, hold the divider in
// reset while the new DIVIDER lands, settle, then reopen the bus.
// Every output comes from a register or is decoded from the state register.
module sd_clock_ctrl #(
  parameter logic [7:0] RESET_DIV     = 8'd1,
  parameter int         HOLD_CYCLES   = 4,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         INIT_CYCLES   = 16000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sd_clock_ctrl_if.slave bus
);

  localparam logic [15:0] LP_HOLD   = 16'(HOLD_CYCLES);
  localparam logic [15:0] LP_SETTLE = 16'(SETTLE_CYCLES);
  localparam logic [15:0] LP_INIT   = 16'(INIT_CYCLES);

  typedef enum logic [2:0] {
    ST_INIT_HOLD = 3'd0,
    ST_INIT_RUN  = 3'd1,
    ST_IDLE      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_SETTLE    = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_divider;
  logic [7:0]  r_pending;
  logic        r_init_done;
  logic        r_switch_done;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  w_divider_nxt;
  logic [7:0]  w_pending_nxt;
  logic        w_init_done_nxt;
  logic        w_switch_done_nxt;
  logic        w_cnt_last;
  logic        w_bus_idle;

  // The single down-counter is loaded on state entry; a state ends on 1.
  assign w_cnt_last = (r_cnt == 16'd1);
  // Both masters must be idle in the same cycle to leave DRAIN.
  assign w_bus_idle = !bus.i_cmd_busy && !bus.i_dat_busy;

  // State register and datapath registers; reset drops any pending request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_INIT_HOLD;
      r_cnt         <= LP_HOLD;
      r_divider     <= RESET_DIV;
      r_pending     <= 8'd0;
      r_init_done   <= 1'b0;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_divider     <= w_divider_nxt;
      r_pending     <= w_pending_nxt;
      r_init_done   <= w_init_done_nxt;
      r_switch_done <= w_switch_done_nxt;
    end
  end

  // Next-state, counter reloads, divider update and completion pulse.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_divider_nxt     = r_divider;
    w_pending_nxt     = r_pending;
    w_init_done_nxt   = r_init_done;
    w_switch_done_nxt = 1'b0;

    case (r_state)
      ST_INIT_HOLD: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_INIT_RUN;
          w_cnt_nxt   = LP_INIT;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      ST_INIT_RUN: begin
        if (w_cnt_last) begin
          w_state_nxt     = ST_IDLE;
          w_init_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      ST_IDLE: begin
        // Ready is high in every IDLE cycle, so valid alone means accept.
        if (bus.i_req_valid) begin
          w_pending_nxt = bus.i_req_div;
          if (bus.i_req_div != r_divider) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            // Nothing to change: report completion without stalling.
            w_switch_done_nxt = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (w_bus_idle) begin
          // New divider value lands on the same edge the divider enters reset.
          w_state_nxt   = ST_HOLD;
          w_cnt_nxt     = LP_HOLD;
          w_divider_nxt = r_pending;
        end
      end

      ST_HOLD: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = LP_SETTLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      ST_SETTLE: begin
        if (w_cnt_last) begin
          w_state_nxt       = ST_IDLE;
          w_switch_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      default: begin
        // Unreachable encodings recover through the power-up sequence.
        w_state_nxt = ST_INIT_HOLD;
        w_cnt_nxt   = LP_HOLD;
      end
    endcase
  end

  // Outputs decoded from the state register or driven straight from registers.
  assign bus.o_req_ready   = (r_state == ST_IDLE);
  assign bus.o_bus_stall   = (r_state != ST_IDLE);
  assign bus.o_div_rst     = (r_state == ST_INIT_HOLD) || (r_state == ST_HOLD);
  assign bus.o_divider     = r_divider;
  assign bus.o_init_done   = r_init_done;
  assign bus.o_switch_done = r_switch_done;
  assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// Directed bench for sd_clock_ctrl with default parameters.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_sd_clock_ctrl;

  localparam logic [2:0] S_INIT_HOLD = 3'd0;
  localparam logic [2:0] S_INIT_RUN  = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sd_clock_ctrl_if u_if ();

  sd_clock_ctrl u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    u_if.i_req_valid = 1'b0;
    u_if.i_req_div   = 8'd0;
    u_if.i_cmd_busy  = 1'b0;
    u_if.i_dat_busy  = 1'b0;
  endtask

  // Power-up: 4 cycles of divider reset, 16000 cycles of slow clock, then IDLE.
  // Called in the first cycle with reset released.
  task automatic test_power_up();
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ({u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done} !== 4'b1100 ||
          u_if.o_divider !== 8'd1 || u_if.o_dbg_state !== S_INIT_HOLD) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL powerup_hold: %0d bad cycles, want 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 15999; i++) begin
      if ({u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done} !== 4'b0100 ||
          u_if.o_divider !== 8'd1 || u_if.o_dbg_state !== S_INIT_RUN) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL powerup_run: %0d bad cycles, want 0", bad);
    end
    n_tests++;
    if (u_if.o_dbg_state !== S_INIT_RUN || u_if.o_init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL powerup_last_run: state %0d done %b, want 1 0",
               u_if.o_dbg_state, u_if.o_init_done);
    end
    tick();
    n_tests++;
    if ({u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done,
         u_if.o_switch_done} !== 5'b00110 || u_if.o_divider !== 8'd1 ||
        u_if.o_dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL powerup_idle: rst/stall/rdy/init/sd %b%b%b%b%b div %0d state %0d, want 00110 1 2",
               u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done,
               u_if.o_switch_done, u_if.o_divider, u_if.o_dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    n_tests++;
    if ({u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done,
         u_if.o_switch_done} !== 5'b11000 || u_if.o_divider !== 8'd1 ||
        u_if.o_dbg_state !== S_INIT_HOLD) begin
      n_fail++;
      $display("FAIL reset_values: rst/stall/rdy/init/sd %b%b%b%b%b div %0d, want 11000 1",
               u_if.o_div_rst, u_if.o_bus_stall, u_if.o_req_ready, u_if.o_init_done,
               u_if.o_switch_done, u_if.o_divider);
    end
    rst_n = 1'b1;
    test_power_up();
  endtask

  // Request equal to the current divider: immediate done, no stall.
  task automatic test_same_value();
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd1;
    tick();
    u_if.i_req_valid = 1'b0;
    n_tests++;
    if ({u_if.o_switch_done, u_if.o_req_ready, u_if.o_bus_stall, u_if.o_div_rst} !== 4'b1100 ||
        u_if.o_divider !== 8'd1 || u_if.o_dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL same_value_done: sd/rdy/stall/rst %b%b%b%b div %0d, want 1100 1",
               u_if.o_switch_done, u_if.o_req_ready, u_if.o_bus_stall, u_if.o_div_rst,
               u_if.o_divider);
    end
    tick();
    n_tests++;
    if ({u_if.o_switch_done, u_if.o_req_ready, u_if.o_bus_stall} !== 3'b010) begin
      n_fail++;
      $display("FAIL same_value_after: sd/rdy/stall %b%b%b, want 010",
               u_if.o_switch_done, u_if.o_req_ready, u_if.o_bus_stall);
    end
  endtask

  // Reset asserted in the middle of HOLD of a 1 -> 0 switch.
  task automatic test_reset_mid_hold();
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd0;
    tick();
    u_if.i_req_valid = 1'b0;
    tick();
    n_tests++;
    if (u_if.o_dbg_state !== S_HOLD || u_if.o_divider !== 8'd0 || u_if.o_div_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL rmh_in_hold: state %0d div %0d rst %b, want 4 0 1",
               u_if.o_dbg_state, u_if.o_divider, u_if.o_div_rst);
    end
    tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({u_if.o_div_rst, u_if.o_init_done, u_if.o_switch_done, u_if.o_req_ready} !== 4'b1000 ||
        u_if.o_divider !== 8'd1 || u_if.o_dbg_state !== S_INIT_HOLD) begin
      n_fail++;
      $display("FAIL rmh_reset: rst/init/sd/rdy %b%b%b%b div %0d state %0d, want 1000 1 0",
               u_if.o_div_rst, u_if.o_init_done, u_if.o_switch_done, u_if.o_req_ready,
               u_if.o_divider, u_if.o_dbg_state);
    end
    rst_n = 1'b1;
    test_power_up();
    tick();
    n_tests++;
    if (u_if.o_switch_done !== 1'b0 || u_if.o_divider !== 8'd1 || u_if.o_dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL rmh_dropped: sd %b div %0d state %0d, want 0 1 2",
               u_if.o_switch_done, u_if.o_divider, u_if.o_dbg_state);
    end
  endtask

  // 1 -> 0 with an idle bus; k counts edges after the acceptance edge.
  task automatic test_switch_fast();
    logic e_rst, e_stall, e_sd;
    int   bad;
    bad = 0;
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd0;
    tick();
    u_if.i_req_valid = 1'b0;
    n_tests++;
    if (u_if.o_dbg_state !== S_DRAIN || u_if.o_divider !== 8'd1 || u_if.o_bus_stall !== 1'b1 ||
        u_if.o_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fast_drain: state %0d div %0d stall %b rdy %b, want 3 1 1 0",
               u_if.o_dbg_state, u_if.o_divider, u_if.o_bus_stall, u_if.o_req_ready);
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      e_rst   = (k <= 4);
      e_stall = (k <= 20);
      e_sd    = (k == 21);
      n_tests++;
      if ({u_if.o_div_rst, u_if.o_bus_stall, u_if.o_switch_done} !== {e_rst, e_stall, e_sd} ||
          u_if.o_divider !== 8'd0) begin
        n_fail++;
        bad++;
        $display("FAIL fast_k%0d: rst/stall/sd %b%b%b div %0d, want %b%b%b 0", k,
                 u_if.o_div_rst, u_if.o_bus_stall, u_if.o_switch_done, u_if.o_divider,
                 e_rst, e_stall, e_sd);
      end
    end
  endtask

  // 0 -> 3 while DAT_BUSY is held 50 cycles; busy re-rises in HOLD.
  task automatic test_drain_busy();
    int bad;
    bad = 0;
    u_if.i_dat_busy  = 1'b1;
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd3;
    tick();
    u_if.i_req_valid = 1'b0;
    u_if.i_req_div   = 8'd9;
    for (int i = 0; i < 50; i++) begin
      if (u_if.o_dbg_state !== S_DRAIN || u_if.o_divider !== 8'd0 || u_if.o_div_rst !== 1'b0 ||
          u_if.o_bus_stall !== 1'b1) bad++;
      tick();
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drain_wait: %0d bad cycles, want 0", bad);
    end
    u_if.i_dat_busy = 1'b0;
    n_tests++;
    if (u_if.o_dbg_state !== S_DRAIN) begin
      n_fail++;
      $display("FAIL drain_last: state %0d, want 3", u_if.o_dbg_state);
    end
    tick();
    n_tests++;
    if (u_if.o_dbg_state !== S_HOLD || u_if.o_divider !== 8'd3 || u_if.o_div_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold: state %0d div %0d rst %b, want 4 3 1",
               u_if.o_dbg_state, u_if.o_divider, u_if.o_div_rst);
    end
    u_if.i_dat_busy = 1'b1;
    u_if.i_cmd_busy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (u_if.o_dbg_state !== S_SETTLE || u_if.o_div_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_settle: state %0d rst %b, want 5 0",
               u_if.o_dbg_state, u_if.o_div_rst);
    end
    for (int i = 0; i < 16; i++) tick();
    n_tests++;
    if (u_if.o_dbg_state !== S_IDLE || u_if.o_switch_done !== 1'b1 || u_if.o_divider !== 8'd3) begin
      n_fail++;
      $display("FAIL drain_done: state %0d sd %b div %0d, want 2 1 3",
               u_if.o_dbg_state, u_if.o_switch_done, u_if.o_divider);
    end
    drive_idle();
    tick();
  endtask

  // 3 -> 0 then 5, the second request raised in the SWITCH_DONE cycle.
  task automatic test_back_to_back();
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd0;
    tick();
    u_if.i_req_valid = 1'b0;
    for (int k = 1; k <= 21; k++) tick();
    n_tests++;
    if (u_if.o_switch_done !== 1'b1 || u_if.o_req_ready !== 1'b1 || u_if.o_divider !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_first: sd %b rdy %b div %0d, want 1 1 0",
               u_if.o_switch_done, u_if.o_req_ready, u_if.o_divider);
    end
    u_if.i_req_valid = 1'b1;
    u_if.i_req_div   = 8'd5;
    tick();
    u_if.i_req_valid = 1'b0;
    n_tests++;
    if (u_if.o_dbg_state !== S_DRAIN || u_if.o_switch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: state %0d sd %b, want 3 0",
               u_if.o_dbg_state, u_if.o_switch_done);
    end
    for (int k = 1; k <= 20; k++) tick();
    n_tests++;
    if (u_if.o_switch_done !== 1'b0 || u_if.o_divider !== 8'd5) begin
      n_fail++;
      $display("FAIL b2b_k20: sd %b div %0d, want 0 5", u_if.o_switch_done, u_if.o_divider);
    end
    tick();
    n_tests++;
    if (u_if.o_switch_done !== 1'b1 || u_if.o_divider !== 8'd5 || u_if.o_dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL b2b_second: sd %b div %0d state %0d, want 1 5 2",
               u_if.o_switch_done, u_if.o_divider, u_if.o_dbg_state);
    end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive_idle();
    test_reset();
    test_same_value();
    test_reset_mid_hold();
    test_switch_fast();
    test_drain_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
